// File: rtl/controle_ignicao_if.sv
// Signal bundle between the ignition controller and the engine-phase/host side.
// The master drives phases, rpm and enables; the slave (controller) returns sparks, counters and flags.
interface controle_ignicao_if;
  logic        enable;
  logic [3:0]  estado_cilindro1;
  logic [3:0]  estado_cilindro2;
  logic [12:0] rpm;
  logic        clr_erro;
  logic        vela1;
  logic        vela2;
  logic [15:0] contador_ign;
  logic [7:0]  perdidas;
  logic        erro_estado;
  logic        erro_fase;
  logic        corte_ativo;

  modport master (
    output enable, estado_cilindro1, estado_cilindro2, rpm, clr_erro,
    input  vela1, vela2, contador_ign, perdidas, erro_estado, erro_fase, corte_ativo
  );

  modport slave (
    input  enable, estado_cilindro1, estado_cilindro2, rpm, clr_erro,
    output vela1, vela2, contador_ign, perdidas, erro_estado, erro_fase, corte_ativo
  );
endinterface

// File: rtl/controle_ignicao.sv
// Two-cylinder spark controller: one pulse FSM per cylinder, spark/lost counters, sticky phase errors.
// Optional rev limiter enabled by defining CORTE_RPM_EN.
//
// state   | meaning
// OCIOSO  | idle, waiting for an entry into the 0010 (ignicao) phase
// DISPARO | spark pulse in progress, down-counter holds remaining clocks
module controle_ignicao #(
  parameter int unsigned PULSE_LARGURA = 3,
  parameter int unsigned RPM_LIMIAR    = 4000,
  parameter int unsigned RPM_CORTE     = 7800
) (
  input logic               clk,
  input logic               reset,
  controle_ignicao_if.slave bus
);

  typedef enum logic {OCIOSO = 1'b0, DISPARO = 1'b1} estado_t;

  localparam int unsigned     MEIA_LARGURA = ((PULSE_LARGURA >> 1) < 1) ? 1 : (PULSE_LARGURA >> 1);
  localparam logic [3:0]      W_BAIXA      = 4'(PULSE_LARGURA);
  localparam logic [3:0]      W_ALTA       = 4'(MEIA_LARGURA);
  localparam logic [3:0]      FASE_IGN     = 4'b0010;

  function automatic logic fase_legal(input logic [3:0] f);
    return (f == 4'b1000) || (f == 4'b0100) || (f == 4'b0010) || (f == 4'b0001);
  endfunction

  logic [3:0]  fase       [2];
  logic [3:0]  fase_ant_q [2];
  estado_t     est_q      [2];
  estado_t     est_d      [2];
  logic [3:0]  cnt_q      [2];
  logic [3:0]  cnt_d      [2];
  logic        vela_q     [2];
  logic        inicio     [2];
  logic        perdida    [2];
  logic [3:0]  largura;
  logic        supressao;
  logic [15:0] cont_ign_q;
  logic [7:0]  perdidas_q;
  logic [16:0] soma_ign;
  logic [8:0]  soma_perd;
  logic        erro_estado_q;
  logic        erro_fase_q;
  logic        set_estado;
  logic        set_fase;

  assign fase[0] = bus.estado_cilindro1;
  assign fase[1] = bus.estado_cilindro2;

  assign largura = (bus.rpm < 13'(RPM_LIMIAR)) ? W_BAIXA : W_ALTA;

`ifdef CORTE_RPM_EN
  // Limiter acts on the registered comparison, so it lags rpm by one clock.
  logic corte_q;

  always_ff @(posedge clk) begin
    if (reset) corte_q <= 1'b0;
    else       corte_q <= (bus.rpm >= 13'(RPM_CORTE));
  end

  assign supressao       = corte_q;
  assign bus.corte_ativo = corte_q;
`else
  assign supressao       = 1'b0;
  assign bus.corte_ativo = 1'b0;
`endif

  always_comb begin
    logic entrada;
    logic aceita;
    for (int i = 0; i < 2; i++) begin
      est_d[i]   = est_q[i];
      cnt_d[i]   = cnt_q[i];
      inicio[i]  = 1'b0;
      perdida[i] = 1'b0;
      entrada    = (fase[i] == FASE_IGN) && (fase_ant_q[i] != FASE_IGN);
      aceita     = entrada && bus.enable && !supressao;
      case (est_q[i])
        OCIOSO: begin
          if (aceita) begin
            est_d[i]  = DISPARO;
            cnt_d[i]  = largura;
            inicio[i] = 1'b1;
          end
        end
        DISPARO: begin
          perdida[i] = aceita;
          if (cnt_q[i] == 4'd1) est_d[i] = OCIOSO;
          else                  cnt_d[i] = cnt_q[i] - 4'd1;
        end
        default: est_d[i] = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        est_q[i]      <= OCIOSO;
        cnt_q[i]      <= 4'd0;
        fase_ant_q[i] <= 4'b0000;
        vela_q[i]     <= 1'b0;
      end else begin
        est_q[i]      <= est_d[i];
        cnt_q[i]      <= cnt_d[i];
        fase_ant_q[i] <= fase[i];
        vela_q[i]     <= (est_d[i] == DISPARO);
      end
    end
  end

  // Both cylinders may start or lose in the same clock, so each counter can step by 2.
  assign soma_ign  = {1'b0, cont_ign_q} + {16'd0, inicio[0]} + {16'd0, inicio[1]};
  assign soma_perd = {1'b0, perdidas_q} + {8'd0, perdida[0]} + {8'd0, perdida[1]};

  assign set_estado = !fase_legal(fase[0]) || !fase_legal(fase[1]);
  assign set_fase   = fase_legal(fase[0]) && fase_legal(fase[1]) && (fase[0] == fase[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_ign_q    <= 16'd0;
      perdidas_q    <= 8'd0;
      erro_estado_q <= 1'b0;
      erro_fase_q   <= 1'b0;
    end else begin
      cont_ign_q    <= soma_ign[16] ? 16'hFFFF : soma_ign[15:0];
      perdidas_q    <= soma_perd[8] ? 8'hFF : soma_perd[7:0];
      erro_estado_q <= set_estado || (erro_estado_q && !bus.clr_erro);
      erro_fase_q   <= set_fase || (erro_fase_q && !bus.clr_erro);
    end
  end

  assign bus.vela1        = vela_q[0];
  assign bus.vela2        = vela_q[1];
  assign bus.contador_ign = cont_ign_q;
  assign bus.perdidas     = perdidas_q;
  assign bus.erro_estado  = erro_estado_q;
  assign bus.erro_fase    = erro_fase_q;

endmodule

// File: tb/tb_controle_ignicao.sv
// Bench for controle_ignicao: timestamp-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_controle_ignicao;

  localparam int PL    = 3;
  localparam int LIM   = 4000;
  localparam int CORTE = 7800;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  controle_ignicao_if ifc ();

  controle_ignicao #(
    .PULSE_LARGURA(PL),
    .RPM_LIMIAR   (LIM),
    .RPM_CORTE    (CORTE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nome, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] f);
    return (f == 4'b1000) || (f == 4'b0100) || (f == 4'b0010) || (f == 4'b0001);
  endfunction

  // Model: a spark started at edge s with width w is high after edges s..s+w-1.
  bit         m_valid = 0;
  int         m_edge;
  int         m_start [2];
  int         m_w     [2];
  logic [3:0] m_prev  [2];
  int         m_cnt, m_lost;
  bit         m_ee, m_ef, m_corte;

  always @(posedge clk) begin : modelo
    int n, starts, lost, w;
    logic [3:0] ph;
    bit entry, busy;
    if (reset) begin
      m_valid <= 1;
      m_edge  <= 0;
      for (int i = 0; i < 2; i++) begin
        m_start[i] <= -100;
        m_w[i]     <= 1;
        m_prev[i]  <= 4'b0000;
      end
      m_cnt <= 0; m_lost <= 0; m_ee <= 0; m_ef <= 0; m_corte <= 0;
    end else begin
      n = m_edge + 1;
      starts = 0;
      lost = 0;
      w = (int'(ifc.rpm) < LIM) ? PL : ((PL / 2 < 1) ? 1 : PL / 2);
      for (int i = 0; i < 2; i++) begin
        ph    = (i == 0) ? ifc.estado_cilindro1 : ifc.estado_cilindro2;
        entry = (ph == 4'b0010) && (m_prev[i] != 4'b0010);
        busy  = (n >= m_start[i] + 1) && (n <= m_start[i] + m_w[i]);
        if (entry && ifc.enable && !m_corte) begin
          if (busy) lost++;
          else begin
            m_start[i] <= n;
            m_w[i]     <= w;
            starts++;
          end
        end
        m_prev[i] <= ph;
      end
      m_cnt  <= (m_cnt + starts > 65535) ? 65535 : m_cnt + starts;
      m_lost <= (m_lost + lost > 255) ? 255 : m_lost + lost;
      m_ee   <= !legal(ifc.estado_cilindro1) || !legal(ifc.estado_cilindro2) || (m_ee && !ifc.clr_erro);
      m_ef   <= (legal(ifc.estado_cilindro1) && legal(ifc.estado_cilindro2) &&
                 ifc.estado_cilindro1 == ifc.estado_cilindro2) || (m_ef && !ifc.clr_erro);
`ifdef CORTE_RPM_EN
      m_corte <= (int'(ifc.rpm) >= CORTE);
`else
      m_corte <= 0;
`endif
      m_edge <= n;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("vela1", ifc.vela1, (m_edge - m_start[0] >= 0) && (m_edge - m_start[0] < m_w[0]));
      chk("vela2", ifc.vela2, (m_edge - m_start[1] >= 0) && (m_edge - m_start[1] < m_w[1]));
      chk("contador_ign", ifc.contador_ign, m_cnt);
      chk("perdidas", ifc.perdidas, m_lost);
      chk("erro_estado", ifc.erro_estado, m_ee);
      chk("erro_fase", ifc.erro_fase, m_ef);
      chk("corte_ativo", ifc.corte_ativo, m_corte);
    end
  end

  logic [3:0] rot [4];

  task automatic drv(input logic [3:0] c1, input logic [3:0] c2);
    ifc.estado_cilindro1 = c1;
    ifc.estado_cilindro2 = c2;
    @(negedge clk);
  endtask

  task automatic lit(input string nome, input longint act, input longint exp);
    #1;
    chk(nome, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(4'b1000, 4'b0100);
    reset = 1'b0;
  endtask

  initial begin
    rot[0] = 4'b1000; rot[1] = 4'b0100; rot[2] = 4'b0010; rot[3] = 4'b0001;
    ifc.enable = 1'b1;
    ifc.rpm = 13'd1000;
    ifc.clr_erro = 1'b0;
    ifc.estado_cilindro1 = 4'b1000;
    ifc.estado_cilindro2 = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    lit("rst_vela1", ifc.vela1, 0);
    lit("rst_contador", ifc.contador_ign, 0);
    lit("rst_erro_estado", ifc.erro_estado, 0);
    reset = 1'b0;

    // Low rpm rotation: 3-clock pulses, both cylinders fire once per rotation.
    for (int i = 0; i < 12; i++) begin
      drv(rot[i % 4], rot[(i + 2) % 4]);
      if (i == 2) lit("low_rise", ifc.vela1, 1);
      if (i == 4) lit("low_third", ifc.vela1, 1);
      if (i == 5) lit("low_fall", ifc.vela1, 0);
    end
    lit("low_contador", ifc.contador_ign, 6);
    lit("low_perdidas", ifc.perdidas, 0);

    // High rpm: pulse shortened to 1 clock.
    ifc.rpm = 13'd5000;
    for (int i = 12; i < 20; i++) begin
      drv(rot[i % 4], rot[(i + 2) % 4]);
      if (i == 14) lit("high_rise", ifc.vela1, 1);
      if (i == 15) lit("high_fall", ifc.vela1, 0);
    end
    lit("high_contador", ifc.contador_ign, 10);

    // Lost spark: entries two clocks apart while a 3-clock pulse runs.
    ifc.rpm = 13'd1000;
    do_reset();
    drv(4'b0010, 4'b0001);
    drv(4'b1000, 4'b0001);
    drv(4'b0010, 4'b0001);
    drv(4'b1000, 4'b0001);
    lit("lost_perdidas", ifc.perdidas, 1);
    lit("lost_contador", ifc.contador_ign, 1);

    // Disabled entries are neither fired nor counted as lost.
    drv(4'b0010, 4'b0001);
    ifc.enable = 1'b0;
    drv(4'b1000, 4'b0001);
    drv(4'b0010, 4'b0001);
    drv(4'b1000, 4'b0001);
    drv(4'b0010, 4'b0001);
    lit("dis_perdidas", ifc.perdidas, 1);
    lit("dis_contador", ifc.contador_ign, 2);
    lit("dis_vela1", ifc.vela1, 0);

    // Saturate the lost counter: fire and loss alternate.
    ifc.enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drv(4'b1000, 4'b0001);
      drv(4'b0010, 4'b0001);
    end
    lit("sat_perdidas", ifc.perdidas, 255);
    lit("sat_contador", ifc.contador_ign, 302);

    // Sticky error flags and set-over-clear priority.
    do_reset();
    drv(4'b1000, 4'b0001);
    drv(4'b0110, 4'b0001);
    lit("err_set", ifc.erro_estado, 1);
    lit("err_no_vela", ifc.vela1, 0);
    drv(4'b0001, 4'b1000);
    lit("err_hold", ifc.erro_estado, 1);
    lit("err_no_vela2", ifc.vela1, 0);
    ifc.clr_erro = 1'b1;
    drv(4'b1111, 4'b1000);
    lit("err_set_wins", ifc.erro_estado, 1);
    drv(4'b0001, 4'b1000);
    lit("err_clear", ifc.erro_estado, 0);
    ifc.clr_erro = 1'b0;
    drv(4'b0100, 4'b0100);
    lit("fase_set", ifc.erro_fase, 1);
    drv(4'b1000, 4'b0100);
    lit("fase_hold", ifc.erro_fase, 1);
    ifc.clr_erro = 1'b1;
    drv(4'b1000, 4'b0100);
    ifc.clr_erro = 1'b0;
    lit("fase_clear", ifc.erro_fase, 0);

    // Rev limiter region.
    ifc.rpm = 13'd7900;
    do_reset();
    drv(4'b1000, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      drv(rot[i % 4], rot[(i + 2) % 4]);
`ifdef CORTE_RPM_EN
      if (i == 2) lit("corte_no_vela", ifc.vela1, 0);
`else
      if (i == 2) lit("corte_vela", ifc.vela1, 1);
      if (i == 3) lit("corte_vela_fall", ifc.vela1, 0);
`endif
    end
`ifdef CORTE_RPM_EN
    lit("corte_contador", ifc.contador_ign, 0);
    lit("corte_ativo", ifc.corte_ativo, 1);
`else
    lit("corte_contador", ifc.contador_ign, 4);
    lit("corte_ativo", ifc.corte_ativo, 0);
`endif

    // Reset during the second clock of a vela2 pulse.
    ifc.rpm = 13'd1000;
    do_reset();
    drv(4'b1000, 4'b0010);
    lit("rst_mid_first", ifc.vela2, 1);
    drv(4'b0100, 4'b0001);
    lit("rst_mid_second", ifc.vela2, 1);
    reset = 1'b1;
    drv(4'b0100, 4'b0001);
    lit("rst_mid_vela2", ifc.vela2, 0);
    lit("rst_mid_contador", ifc.contador_ign, 0);
    reset = 1'b0;
    drv(4'b1000, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_ignicao.md
CONTROLE_IGNICAO -- requirements
Module: controle_ignicao

Interface
REQ-001 SHALL have parameter PULSE_LARGURA, default 3, spark pulse width in clocks at low rpm (legal 1..15).
REQ-002 SHALL have parameter RPM_LIMIAR, default 4000, rpm at or above which the pulse is shortened.
REQ-003 SHALL have parameter RPM_CORTE, default 7800, rev-limiter threshold (used only with CORTE_RPM_EN).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, spark enable.
REQ-007 SHALL have port estado_cilindro1, input, 4, one-hot phase of cylinder 1: 1000 admissao, 0100 compressao, 0010 ignicao, 0001 exaustao.
REQ-008 SHALL have port estado_cilindro2, input, 4, cylinder 2 phase, same encoding.
REQ-009 SHALL have port rpm, input, 13, engine speed 0..8000.
REQ-010 SHALL have port clr_erro, input, 1, clears sticky error flags.
REQ-011 SHALL have ports vela1 and vela2, output, 1 each, registered spark pulses for cylinders 1 and 2.
REQ-012 SHALL have port contador_ign, output, 16, count of issued sparks, saturating at 0xFFFF.
REQ-013 SHALL have port perdidas, output, 8, count of lost sparks, saturating at 0xFF.
REQ-014 SHALL have ports erro_estado and erro_fase, output, 1 each, sticky error flags.
REQ-015 SHALL have port corte_ativo, output, 1, rev limiter active.

Function
REQ-016 SHALL register each cylinder's previous phase; an entry is sampled phase == 0010 while the registered previous phase != 0010.
REQ-017 SHALL run one FSM per cylinder with states OCIOSO and DISPARO.
REQ-018 OCIOSO -> DISPARO on entry when enable=1 and spark not suppressed; the vela output SHALL rise on the next edge (latency 1 clock after the entry is sampled).
REQ-019 SHALL latch pulse width W at entry: W=PULSE_LARGURA if rpm<RPM_LIMIAR, else max(1, PULSE_LARGURA>>1).
REQ-020 vela SHALL stay high exactly W clocks, then the FSM SHALL return to OCIOSO.
REQ-021 An entry arriving while that cylinder is in DISPARO SHALL be ignored, SHALL NOT retrigger, and SHALL increment perdidas by 1.
REQ-022 enable=0 SHALL block new entries without counting them as lost; a pulse in progress SHALL complete.
REQ-023 contador_ign SHALL increment on each OCIOSO->DISPARO transition; simultaneous starts on both cylinders SHALL add 2 (saturating).
REQ-024 erro_estado SHALL set on the next edge when either phase input is not one of the four legal codes.
REQ-025 erro_fase SHALL set when both phase inputs are legal and equal.
REQ-026 Illegal codes SHALL never produce an entry.
REQ-027 Both error flags SHALL hold until clr_erro=1; if a set condition coincides with clr_erro, set wins.

Reset
REQ-028 reset=1 SHALL, at the next edge, force FSMs to OCIOSO, previous phases to 0000, and vela1, vela2, contador_ign, perdidas, erro_estado, erro_fase and corte_ativo to 0, aborting any pulse in progress.
REQ-029 Because previous phases reset to 0000, a cylinder sampled in 0010 on the first cycle after reset SHALL fire.

Configuration
REQ-030 With macro CORTE_RPM_EN defined, corte_ativo SHALL be registered (rpm>=RPM_CORTE); while it is 1, entries SHALL be suppressed, not counted in contador_ign or perdidas, and in-progress pulses SHALL complete.
REQ-031 Without CORTE_RPM_EN, corte_ativo SHALL be constant 0 and no suppression logic SHALL exist.

Verification
REQ-032 rpm=1000, enable=1, C1 rotating 1000->0100->0010->0001 once per clock -> vela1 high 3 clocks starting 1 clock after each 0010 sample; contador_ign +1 per rotation; perdidas=0.
REQ-033 Same stimulus with rpm=5000 -> vela1 pulses of 1 clock.
REQ-034 PULSE_LARGURA=6, rpm=1000, 4-clock rotation -> every second entry is lost; after 4 rotations contador_ign=2 and perdidas=2.
REQ-035 estado_cilindro1=0110 for one clock -> erro_estado=1 from the next clock until clr_erro pulse; no vela1 pulse is produced.
REQ-036 rpm=7900 with rotating phases -> with CORTE_RPM_EN: corte_ativo=1, no vela pulses, counters static; without the macro: normal 1-clock pulses.
REQ-037 reset asserted during the 2nd clock of a vela2 pulse -> vela2=0 and contador_ign=0 at the next edge.
